// File: rtl/mem_burst_reader.sv
// Burst read initiator: fetches len_i consecutive words over req/ready and streams them out through a small FIFO.
// Optional MEM_READER_STRIDE_EN adds a stride_i port for a programmable address step.
module mem_burst_reader #(
  parameter int DWidth    = 32,
  parameter int LenWidth  = 16,
  parameter int FifoDepth = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [DWidth-1:0]   base_addr_i,
`ifdef MEM_READER_STRIDE_EN
  input  logic [DWidth-1:0]   stride_i,
`endif
  input  logic [LenWidth-1:0] len_i,
  input  logic                abort_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                mem_req_o,
  output logic                mem_write_o,
  output logic [DWidth-1:0]   mem_addr_o,
  output logic [DWidth-1:0]   mem_wdata_o,
  input  logic                mem_ready_i,
  input  logic [DWidth-1:0]   mem_rdata_i,
  output logic                data_valid_o,
  output logic [DWidth-1:0]   data_o,
  input  logic                data_ready_i
);

  // state | meaning
  // IDLE  | waiting for start_i
  // ISSUE | waiting for FIFO space before the next request
  // REQ   | request held until mem_ready_i
  // DONE  | one-cycle done_o pulse
  typedef enum logic [1:0] {IDLE, ISSUE, REQ, DONE} state_e;

  localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CntW = $clog2(FifoDepth) + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(FifoDepth);

  state_e state_q, state_d;
  logic [DWidth-1:0]   addr_q;
  logic [DWidth-1:0]   step;
  logic [LenWidth-1:0] remaining_q;
  logic                abort_q;
  logic                abort_eff;
  logic                push, pop, flush;
  logic [DWidth-1:0]   mem_q [FifoDepth];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q;
  logic                unused_bits;

`ifdef MEM_READER_STRIDE_EN
  logic [DWidth-1:0] stride_q;
  assign step        = stride_q;
  assign unused_bits = ^{base_addr_i[1:0], stride_i[1:0]};
`else
  assign step        = DWidth'(4);
  assign unused_bits = ^base_addr_i[1:0];
`endif

  // A pending abort is honoured even after abort_i has dropped again.
  assign abort_eff = abort_q | abort_i;
  assign push  = (state_q == REQ) && mem_ready_i && !abort_eff;
  assign pop   = (count_q != '0) && data_ready_i;
  assign flush = ((state_q == ISSUE) && abort_eff) ||
                 ((state_q == REQ) && mem_ready_i && abort_eff);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start_i) state_d = (len_i != '0) ? ISSUE : DONE;
      ISSUE: begin
        if (abort_eff)              state_d = DONE;
        else if (count_q < FullCnt) state_d = REQ;
      end
      REQ: begin
        if (mem_ready_i) begin
          if (abort_eff || remaining_q == LenWidth'(1)) state_d = DONE;
          else                                          state_d = ISSUE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q      <= '0;
      remaining_q <= '0;
      abort_q     <= 1'b0;
`ifdef MEM_READER_STRIDE_EN
      stride_q    <= '0;
`endif
    end else begin
      if (state_q == IDLE && start_i && len_i != '0) begin
        addr_q      <= {base_addr_i[DWidth-1:2], 2'b00};
        remaining_q <= len_i;
`ifdef MEM_READER_STRIDE_EN
        stride_q    <= {stride_i[DWidth-1:2], 2'b00};
`endif
      end else if (push) begin
        addr_q      <= addr_q + step;
        remaining_q <= remaining_q - LenWidth'(1);
      end
      if (state_q == ISSUE || state_q == REQ) begin
        if (abort_i) abort_q <= 1'b1;
      end else begin
        abort_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FifoDepth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= mem_rdata_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign mem_req_o    = (state_q == REQ);
  assign mem_write_o  = 1'b0;
  assign mem_wdata_o  = '0;
  assign mem_addr_o   = addr_q;
  assign data_valid_o = (count_q != '0);
  assign data_o       = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_mem_burst_reader.sv
// Directed bench for mem_burst_reader; responder answers each request 4 cycles after it rises.
// Define MEM_READER_STRIDE_EN to also exercise the stride port.
module tb_mem_burst_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, data_ready;
  logic [31:0] base_addr;
  logic [15:0] len;
  logic        busy, done, mem_req, mem_write, mem_ready, data_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, data;
`ifdef MEM_READER_STRIDE_EN
  logic [31:0] stride;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] addr_log[$];
  logic [31:0] rx_log[$];
  int          txns, done_cnt, rsp_cnt;
  bit          req_seen;

  always #5 clk = ~clk;

  mem_burst_reader #(.DWidth(32), .LenWidth(16), .FifoDepth(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .base_addr_i(base_addr),
`ifdef MEM_READER_STRIDE_EN
    .stride_i(stride),
`endif
    .len_i(len), .abort_i(abort), .busy_o(busy), .done_o(done),
    .mem_req_o(mem_req), .mem_write_o(mem_write), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata),
    .data_valid_o(data_valid), .data_o(data), .data_ready_i(data_ready)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Responder and output monitor, both away from the active edge.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (mem_req) req_seen = 1'b1;
    if (data_valid && data_ready) rx_log.push_back(data);
    if (!rst_n) begin
      mem_ready = 1'b0;
      rsp_cnt   = 0;
    end else if (mem_ready) begin
      mem_ready = 1'b0;
      rsp_cnt   = 0;
    end else if (mem_req) begin
      rsp_cnt++;
      if (rsp_cnt == 4) begin
        mem_ready = 1'b1;
        mem_rdata = word_of(mem_addr);
        addr_log.push_back(mem_addr);
        txns++;
      end
    end else begin
      rsp_cnt = 0;
    end
  end

  task automatic clear_logs();
    addr_log.delete();
    rx_log.delete();
    txns = 0; done_cnt = 0; req_seen = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] b, input logic [15:0] l);
    @(posedge clk); #1;
    base_addr = b; len = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_cnt > 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; abort = 0; data_ready = 0;
    base_addr = '0; len = '0; mem_ready = 0; mem_rdata = '0;
`ifdef MEM_READER_STRIDE_EN
    stride = '0;
`endif
    clear_logs();
    #23;
    total++; if ({busy, done, mem_req, data_valid} !== 4'b0000) begin bad++;
      $display("FAIL reset_flags got=%b want=0000", {busy, done, mem_req, data_valid}); end
    total++; if (mem_addr !== 32'h0 || data !== 32'h0) begin bad++;
      $display("FAIL reset_addr_data addr=%h data=%h want 0", mem_addr, data); end
    total++; if (mem_write !== 1'b0 || mem_wdata !== 32'h0) begin bad++;
      $display("FAIL reset_write got=%b/%h want 0/0", mem_write, mem_wdata); end
    @(negedge clk); rst_n = 1'b1;
    cycles(2);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b want=0", busy); end
  endtask

  task automatic test_basic();
    bit ok;
    logic [31:0] exp [3] = '{32'h100, 32'h104, 32'h108};
    clear_logs();
    data_ready = 1'b1;
    @(posedge clk); #1;
    base_addr = 32'h0000_0102; len = 16'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (busy !== 1'b1 || mem_req !== 1'b0) begin bad++;
      $display("FAIL basic_issue busy=%b req=%b want 1/0", busy, mem_req); end
    @(posedge clk); #1;
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin bad++;
      $display("FAIL basic_req_latency req=%b addr=%h want 1/00000100", mem_req, mem_addr); end
    wait_done(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_done_timeout got=none want=pulse"); end
    cycles(4);
    total++; if (addr_log.size() !== 3 || rx_log.size() !== 3) begin bad++;
      $display("FAIL basic_counts addrs=%0d words=%0d want 3/3", addr_log.size(), rx_log.size()); end
    for (int i = 0; i < 3 && i < addr_log.size() && i < rx_log.size(); i++) begin
      total++; if (addr_log[i] !== exp[i] || rx_log[i] !== word_of(exp[i])) begin bad++;
        $display("FAIL basic_item%0d addr=%h data=%h want %h/%h", i, addr_log[i], rx_log[i],
                 exp[i], word_of(exp[i])); end
    end
    total++; if (done_cnt !== 1 || busy !== 1'b0) begin bad++;
      $display("FAIL basic_end done_pulses=%0d busy=%b want 1/0", done_cnt, busy); end
  endtask

  task automatic test_len_zero();
    clear_logs();
    pulse_start(32'h200, 16'd0);
    cycles(6);
    total++; if (done_cnt !== 1 || req_seen !== 1'b0 || txns !== 0) begin bad++;
      $display("FAIL len0 done_pulses=%0d req_seen=%b txns=%0d want 1/0/0", done_cnt, req_seen, txns); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL len0_busy got=%b want=0", busy); end
  endtask

  task automatic test_fifo_full();
    bit ok;
    clear_logs();
    data_ready = 1'b0;
    pulse_start(32'h300, 16'd6);
    cycles(60);
    total++; if (txns !== 4 || mem_req !== 1'b0 || busy !== 1'b1) begin bad++;
      $display("FAIL full_stall txns=%0d req=%b busy=%b want 4/0/1", txns, mem_req, busy); end
    total++; if (data_valid !== 1'b1 || data !== word_of(32'h300)) begin bad++;
      $display("FAIL full_head valid=%b data=%h want 1/%h", data_valid, data, word_of(32'h300)); end
    data_ready = 1'b1;
    wait_done(150, ok);
    total++; if (!ok) begin bad++; $display("FAIL full_done_timeout got=none want=pulse"); end
    cycles(6);
    total++; if (txns !== 6 || rx_log.size() !== 6) begin bad++;
      $display("FAIL full_counts txns=%0d words=%0d want 6/6", txns, rx_log.size()); end
    for (int i = 0; i < 6 && i < rx_log.size(); i++) begin
      total++; if (rx_log[i] !== word_of(32'h300 + 32'(4 * i))) begin bad++;
        $display("FAIL full_word%0d got=%h want=%h", i, rx_log[i], word_of(32'h300 + 32'(4 * i))); end
    end
  endtask

  task automatic test_abort();
    bit ok;
    clear_logs();
    data_ready = 1'b1;
    pulse_start(32'h400, 16'd4);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    total++; if (!ok) begin bad++; $display("FAIL abort_req_timeout got=none want=req"); end
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    total++; if (mem_req !== 1'b1) begin bad++;
      $display("FAIL abort_req_held got=%b want=1", mem_req); end
    wait_done(30, ok);
    total++; if (!ok) begin bad++; $display("FAIL abort_done_timeout got=none want=pulse"); end
    cycles(20);
    total++; if (txns !== 1 || rx_log.size() !== 0 || data_valid !== 1'b0) begin bad++;
      $display("FAIL abort_drop txns=%0d words=%0d valid=%b want 1/0/0", txns, rx_log.size(), data_valid); end
    total++; if (done_cnt !== 1 || busy !== 1'b0 || mem_req !== 1'b0) begin bad++;
      $display("FAIL abort_end done=%0d busy=%b req=%b want 1/0/0", done_cnt, busy, mem_req); end
  endtask

  task automatic test_wrap();
    bit ok;
    clear_logs();
    pulse_start(32'hFFFF_FFFC, 16'd2);
    wait_done(60, ok);
    total++; if (!ok) begin bad++; $display("FAIL wrap_done_timeout got=none want=pulse"); end
    cycles(3);
    total++; if (addr_log.size() !== 2) begin bad++;
      $display("FAIL wrap_count got=%0d want=2", addr_log.size()); end
    else begin
      total++; if (addr_log[0] !== 32'hFFFF_FFFC || addr_log[1] !== 32'h0) begin bad++;
        $display("FAIL wrap_addrs got=%h,%h want fffffffc,00000000", addr_log[0], addr_log[1]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_logs();
    pulse_start(32'h500, 16'd3);
    cycles(2);
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rstmid_pre_req got=%b want=1", mem_req); end
    rst_n = 1'b0;
    #1;
    total++; if ({busy, done, mem_req, data_valid} !== 4'b0000 || mem_addr !== 32'h0) begin bad++;
      $display("FAIL rstmid_async flags=%b addr=%h want 0000/0", {busy, done, mem_req, data_valid}, mem_addr); end
    cycles(3);
    @(negedge clk); rst_n = 1'b1;
    total++; if (done_cnt !== 0) begin bad++; $display("FAIL rstmid_no_done got=%0d want=0", done_cnt); end
    clear_logs();
    pulse_start(32'h600, 16'd2);
    wait_done(60, ok);
    total++; if (!ok) begin bad++; $display("FAIL rstmid_restart_timeout got=none want=pulse"); end
    cycles(4);
    total++; if (rx_log.size() !== 2) begin bad++;
      $display("FAIL rstmid_restart_count got=%0d want=2", rx_log.size()); end
    else begin
      total++; if (rx_log[0] !== word_of(32'h600) || rx_log[1] !== word_of(32'h604)) begin bad++;
        $display("FAIL rstmid_restart_words got=%h,%h want %h,%h", rx_log[0], rx_log[1],
                 word_of(32'h600), word_of(32'h604)); end
    end
  endtask

`ifdef MEM_READER_STRIDE_EN
  task automatic test_stride();
    bit ok;
    logic [31:0] exp [3] = '{32'h200, 32'h210, 32'h220};
    clear_logs();
    stride = 32'h13;
    pulse_start(32'h200, 16'd3);
    wait_done(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL stride_done_timeout got=none want=pulse"); end
    cycles(3);
    total++; if (addr_log.size() !== 3) begin bad++;
      $display("FAIL stride_count got=%0d want=3", addr_log.size()); end
    for (int i = 0; i < 3 && i < addr_log.size(); i++) begin
      total++; if (addr_log[i] !== exp[i]) begin bad++;
        $display("FAIL stride_addr%0d got=%h want=%h", i, addr_log[i], exp[i]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_fifo_full();
    test_abort();
    test_wrap();
    test_reset_mid();
`ifdef MEM_READER_STRIDE_EN
    test_stride();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
